// File: rtl/craft_pkg.sv
// rtl/craft_pkg.sv - CRAFT constants, Q permutation, FSM states and round-constant LFSR helpers
package craft_pkg;

    localparam int CRAFT_ROUNDS  = 32;
    localparam int CRAFT_NIBBLES = 16;

    // Nibble i of Q(T) (i = 0 is the MSB nibble) is copied from nibble CRAFT_Q[i] of T.
    localparam logic [63:0] CRAFT_Q = 64'hCAF5_E892_B374_601D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } craft_state_t;

    function automatic int q_src(input int i);
        return int'(CRAFT_Q[63-4*i -: 4]);
    endfunction

    function automatic logic [3:0] lfsr_a_fwd(input logic [3:0] a);
        return {a[0] ^ a[1], a[3], a[2], a[1]};
    endfunction

    function automatic logic [2:0] lfsr_b_fwd(input logic [2:0] b);
        return {b[0] ^ b[1], b[2], b[1]};
    endfunction

    function automatic logic [3:0] lfsr_a_inv(input logic [3:0] a);
        return {a[2], a[1], a[0], a[3] ^ a[0]};
    endfunction

    function automatic logic [2:0] lfsr_b_inv(input logic [2:0] b);
        return {b[1], b[0], b[2] ^ b[0]};
    endfunction

    // Forward LFSR state after a number of steps from the round-0 seed.
    function automatic logic [3:0] lfsr_a_after(input int steps);
        logic [3:0] a;
        a = 4'b0001;
        for (int i = 0; i < steps; i++) a = lfsr_a_fwd(a);
        return a;
    endfunction

    function automatic logic [2:0] lfsr_b_after(input int steps);
        logic [2:0] b;
        b = 3'b001;
        for (int i = 0; i < steps; i++) b = lfsr_b_fwd(b);
        return b;
    endfunction

    // Constants of the last encryption round: the decryption walk starts here.
    localparam logic [3:0] CRAFT_RC_A_LAST = lfsr_a_after(CRAFT_ROUNDS - 1);
    localparam logic [2:0] CRAFT_RC_B_LAST = lfsr_b_after(CRAFT_ROUNDS - 1);

endpackage

// File: rtl/craft_tweakey_sel.sv
// rtl/craft_tweakey_sel.sv - combinational selection of one round-tweakey nibble
// Ports:
//   k0, k1   : latched key halves K0, K1
//   t        : latched tweak T
//   tk_idx   : which tweakey (TK0..TK3)
//   nib_idx  : nibble index, 0 = bits [63:60]
//   tk_nib   : selected nibble
module craft_tweakey_sel
    import craft_pkg::*;
(
    input  logic [63:0] k0,
    input  logic [63:0] k1,
    input  logic [63:0] t,
    input  logic [1:0]  tk_idx,
    input  logic [3:0]  nib_idx,
    output logic [3:0]  tk_nib
);

    logic [63:0] qt;
    logic [63:0] tk;

    always_comb begin
        qt = '0;
        for (int i = 0; i < 16; i++) begin
            qt[63-4*i -: 4] = t[63-4*q_src(i) -: 4];
        end
    end

    always_comb begin
        tk = '0;
        case (tk_idx)
            2'd0:    tk = k0 ^ t;
            2'd1:    tk = k1 ^ t;
            2'd2:    tk = k0 ^ qt;
            default: tk = k1 ^ qt;
        endcase
    end

    // ~nib_idx * 4 is the LSB position of nibble nib_idx counted from the MSB.
    assign tk_nib = tk[{~nib_idx, 2'b00} +: 4];

endmodule

// File: rtl/craft_inv_key_register.sv
// rtl/craft_inv_key_register.sv - nibble-serial CRAFT tweakey/round-constant generator, reverse round order
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle pulse, latches key/tweak and (re)starts at round 31
//   en           : advance enable, stream stalls while low
//   key, tweak   : K0 = key[127:64], K1 = key[63:0], T = tweak (sampled on start only)
//   out          : current tweakey nibble
//   rc           : round constant {a, 0, b} of the current round
//   r            : current round index, counting down
//   ck0          : out carries nibble 0 of a round
//   valid        : out/rc/r meaningful
//   done         : one-cycle pulse after the last nibble of round 0
module craft_inv_key_register
    import craft_pkg::*;
#(
    parameter int ROUNDS  = CRAFT_ROUNDS,
    parameter int NIBBLES = CRAFT_NIBBLES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      en,
    input  logic [127:0]              key,
    input  logic [63:0]               tweak,
    output logic [3:0]                out,
    output logic [7:0]                rc,
    output logic [$clog2(ROUNDS)-1:0] r,
    output logic                      ck0,
    output logic                      valid,
    output logic                      done
);

    localparam int RW = $clog2(ROUNDS);
    localparam int NW = $clog2(NIBBLES);
    localparam logic [RW-1:0] R_LAST   = RW'(ROUNDS - 1);
    localparam logic [NW-1:0] NIB_LAST = NW'(NIBBLES - 1);

    craft_state_t  state_q, state_d;
    logic [RW-1:0] r_q;
    logic [NW-1:0] nib_q;
    logic [3:0]    a_q;
    logic [2:0]    b_q;
    logic [63:0]   k0_q, k1_q, t_q;
    logic [3:0]    tk_nib;
    logic          last_nib;

    assign last_nib = (nib_q == NIB_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (start)                                    state_d = ST_RUN;
                else if (en && last_nib && (r_q == '0))       state_d = ST_DONE;
            end
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // start wins over en in every state, so a restart mid-run reloads everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= '0;
            nib_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            k0_q  <= '0;
            k1_q  <= '0;
            t_q   <= '0;
        end else if (start) begin
            k0_q  <= key[127:64];
            k1_q  <= key[63:0];
            t_q   <= tweak;
            r_q   <= R_LAST;
            nib_q <= '0;
            a_q   <= CRAFT_RC_A_LAST;
            b_q   <= CRAFT_RC_B_LAST;
        end else if ((state_q == ST_RUN) && en) begin
            if (last_nib) begin
                nib_q <= '0;
                r_q   <= r_q - 1'b1;
                a_q   <= lfsr_a_inv(a_q);
                b_q   <= lfsr_b_inv(b_q);
            end else begin
                nib_q <= nib_q + 1'b1;
            end
        end
    end

    craft_tweakey_sel u_sel (
        .k0      (k0_q),
        .k1      (k1_q),
        .t       (t_q),
        .tk_idx  (r_q[1:0]),
        .nib_idx (nib_q),
        .tk_nib  (tk_nib)
    );

    assign valid = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign ck0   = valid && (nib_q == '0);
    assign out   = valid ? tk_nib : 4'h0;
    assign rc    = valid ? {a_q, 1'b0, b_q} : 8'h00;
    assign r     = valid ? r_q : '0;

endmodule
